// File: rtl/ads7822_scan_ctrl.sv
// ADS7822 scan sequencer: periodic conversion triggers, block averaging, debounced
// OV/UV flags and interface timeout. Define ADC_OFFSET_CAL_EN for offset subtraction.
module ads7822_scan_ctrl #(
  parameter int SAMPLE_PERIOD = 1000,
  parameter int TRIG_WIDTH    = 4,
  parameter int TIMEOUT       = 900,
  parameter int AVG_SHIFT     = 2,
  parameter int DEB_CNT       = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  output logic        ad_trigger,
  input  logic [11:0] sample_data,
  input  logic        data_valid,
  input  logic [11:0] ov_thresh,
  input  logic [11:0] uv_thresh,
  input  logic        fault_clr,
`ifdef ADC_OFFSET_CAL_EN
  input  logic [11:0] adc_offset,
`endif
  output logic [11:0] avg_data,
  output logic        avg_valid,
  output logic        ov_fault,
  output logic        uv_fault,
  output logic        ad_timeout,
  output logic        busy
);
  localparam int DATA_W = 12;
  localparam int ACC_W  = DATA_W + AVG_SHIFT;
  localparam int PCNT_W = $clog2(SAMPLE_PERIOD);
  localparam logic [PCNT_W-1:0]    PER_LAST  = PCNT_W'(SAMPLE_PERIOD - 1);
  localparam logic [PCNT_W-1:0]    TRIG_LAST = PCNT_W'(TRIG_WIDTH - 1);
  localparam logic [PCNT_W-1:0]    TMO_LAST  = PCNT_W'(TRIG_WIDTH + TIMEOUT - 1);
  localparam logic [AVG_SHIFT-1:0] SCNT_LAST = '1;
  localparam logic [3:0]           DEB_LAST  = 4'(DEB_CNT);

  typedef enum logic [1:0] {IDLE, TRIG, WAIT, GAP} state_t;

  state_t               state, state_next;
  logic [PCNT_W-1:0]    period_cnt;
  logic                 capture, timeout_hit;
  logic [DATA_W-1:0]    sample_in;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic [AVG_SHIFT-1:0] sample_cnt;
  logic [3:0]           ov_cnt, uv_cnt;

`ifdef ADC_OFFSET_CAL_EN
  function automatic logic [DATA_W-1:0] sub_sat(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction
`endif

  function automatic logic [DATA_W-1:0] avg_trunc(input logic [ACC_W-1:0] sum);
    return sum[AVG_SHIFT +: DATA_W];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // period_cnt doubles as the TRIG width counter and the WAIT timeout counter
  always_comb begin
    state_next  = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: if (enable) state_next = TRIG;
      TRIG: if (period_cnt == TRIG_LAST) state_next = WAIT;
      WAIT: begin
        if (data_valid) begin
          capture    = 1'b1;
          state_next = GAP;
        end else if (period_cnt == TMO_LAST) begin
          timeout_hit = 1'b1;
          state_next  = GAP;
        end
      end
      GAP: if (period_cnt == PER_LAST) state_next = enable ? TRIG : IDLE;
      default: state_next = IDLE;
    endcase
    ad_trigger = (state == TRIG);
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   period_cnt <= '0;
    else if (state_next == TRIG && state != TRIG) period_cnt <= '0;
    else if (period_cnt != PER_LAST)              period_cnt <= period_cnt + 1'b1;
  end

`ifdef ADC_OFFSET_CAL_EN
  assign sample_in = sub_sat(sample_data, adc_offset);
`else
  assign sample_in = sample_data;
`endif
  assign acc_sum = acc + ACC_W'(sample_in);

  // capture stage: accumulate, emit the block average on the last sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= '0;
      sample_cnt <= '0;
      avg_data   <= '0;
      avg_valid  <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (capture) begin
        if (sample_cnt == SCNT_LAST) begin
          acc        <= '0;
          sample_cnt <= '0;
          avg_data   <= avg_trunc(acc_sum);
          avg_valid  <= 1'b1;
        end else begin
          acc        <= acc_sum;
          sample_cnt <= sample_cnt + 1'b1;
        end
      end
    end
  end

  // fault stage: debounce on each new average; the counter parks at DEB_CNT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ov_cnt     <= '0;
      uv_cnt     <= '0;
      ov_fault   <= 1'b0;
      uv_fault   <= 1'b0;
      ad_timeout <= 1'b0;
    end else if (fault_clr) begin
      ov_cnt     <= '0;
      uv_cnt     <= '0;
      ov_fault   <= 1'b0;
      uv_fault   <= 1'b0;
      ad_timeout <= 1'b0;
    end else begin
      if (timeout_hit) ad_timeout <= 1'b1;
      if (avg_valid) begin
        if (avg_data > ov_thresh) begin
          if (ov_cnt != DEB_LAST) ov_cnt <= ov_cnt + 1'b1;
          if (ov_cnt >= DEB_LAST - 4'd1) ov_fault <= 1'b1;
        end else begin
          ov_cnt <= '0;
        end
        if (avg_data < uv_thresh) begin
          if (uv_cnt != DEB_LAST) uv_cnt <= uv_cnt + 1'b1;
          if (uv_cnt >= DEB_LAST - 4'd1) uv_fault <= 1'b1;
        end else begin
          uv_cnt <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_ads7822_scan_ctrl.sv
// Bench for ads7822_scan_ctrl: a random-latency ADC responder feeds random sample
// blocks; averages and fault timing are compared with a block-average/debounce model.
module tb_ads7822_scan_ctrl;
  localparam int SP = 1000, TW = 4, TO = 900, SH = 2, DEB = 3, N = 1 << SH;

  logic        clk = 1'b0, rst_n = 1'b0, enable = 1'b0, data_valid = 1'b0, fault_clr = 1'b0;
  logic [11:0] sample_data = '0, ov_thresh = 12'hFFF, uv_thresh = '0;
  logic        ad_trigger, avg_valid, ov_fault, uv_fault, ad_timeout, busy;
  logic [11:0] avg_data;
`ifdef ADC_OFFSET_CAL_EN
  logic [11:0] adc_offset = '0;
`endif

  int cyc = 0, n_checks = 0, n_err = 0;
  int send_q[$];
  int dv_q[$], trig_q[$], avg_q[$], avgc_q[$], ovr_q[$], uvr_q[$], tor_q[$];
  int exp_avg[$];
  logic trig_d = 1'b0, ov_d = 1'b0, uv_d = 1'b0, to_d = 1'b0;

  ads7822_scan_ctrl dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .ad_trigger(ad_trigger),
    .sample_data(sample_data), .data_valid(data_valid),
    .ov_thresh(ov_thresh), .uv_thresh(uv_thresh), .fault_clr(fault_clr),
`ifdef ADC_OFFSET_CAL_EN
    .adc_offset(adc_offset),
`endif
    .avg_data(avg_data), .avg_valid(avg_valid), .ov_fault(ov_fault),
    .uv_fault(uv_fault), .ad_timeout(ad_timeout), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ad_trigger && !trig_d) trig_q.push_back(cyc);
    if (avg_valid) begin
      avg_q.push_back(int'(avg_data));
      avgc_q.push_back(cyc);
    end
    if (ov_fault && !ov_d) ovr_q.push_back(cyc);
    if (uv_fault && !uv_d) uvr_q.push_back(cyc);
    if (ad_timeout && !to_d) tor_q.push_back(cyc);
    trig_d <= ad_trigger;
    ov_d   <= ov_fault;
    uv_d   <= uv_fault;
    to_d   <= ad_timeout;
  end

  // ADC interface model: one queued sample per trigger, nothing if the queue is empty
  initial begin
    forever begin
      @(posedge ad_trigger);
      if (send_q.size() > 0) begin
        int lat;
        int s;
        lat = int'($urandom_range(600, 800));
        s = send_q.pop_front();
        repeat (lat) @(posedge clk);
        #1;
        sample_data = 12'(s);
        data_valid  = 1'b1;
        dv_q.push_back(cyc);
        @(posedge clk);
        #1;
        data_valid  = 1'b0;
        sample_data = 12'($urandom);
      end
    end
  end

  function automatic int sat_off(input int s);
`ifdef ADC_OFFSET_CAL_EN
    return (s > int'(adc_offset)) ? s - int'(adc_offset) : 0;
`else
    return s;
`endif
  endfunction

  task automatic push4(input int a, input int b, input int c, input int d);
    send_q.push_back(a); send_q.push_back(b); send_q.push_back(c); send_q.push_back(d);
    exp_avg.push_back((sat_off(a) + sat_off(b) + sat_off(c) + sat_off(d)) / N);
  endtask

  task automatic gen_group(input int target);
    int s[N];
    int tot = 0;
    int spread = (target / 4 < 200) ? target / 4 : 200;
    for (int i = 0; i < N - 1; i++) begin
      s[i] = target - spread + int'($urandom_range(0, 2 * spread));
      tot += s[i];
    end
    s[N-1] = N * target + int'($urandom_range(0, N - 1)) - tot;
    push4(s[0], s[1], s[2], s[3]);
  endtask

  // index of the average on which a fault should latch, -1 if never
  function automatic int first_fault(input int eb, input int ng, input int th, input bit over);
    int run = 0;
    for (int g = 0; g < ng; g++) begin
      if (over ? (exp_avg[eb+g] > th) : (exp_avg[eb+g] < th)) run++;
      else run = 0;
      if (run >= DEB) return g;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return avg_q.size();
      1:       return trig_q.size();
      default: return tor_q.size();
    endcase
  endfunction

  task automatic wait_q(input int which, input int n, input int budget, input string tag);
    int k = 0;
    while (qsize(which) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(qsize(which) >= n), 1);
  endtask

  task automatic wait_idle(input int budget, input string tag, output int c);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, int'(busy), 0);
    c = cyc;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
  endtask

  task automatic check_groups(input string tag, input int ab, input int eb, input int db,
                              input int ng, input int ob, input int ub,
                              input int ovt, input int uvt);
    int idx;
    for (int g = 0; g < ng; g++) begin
      if (avg_q.size() > ab + g) check({tag, "_avg"}, avg_q[ab+g], exp_avg[eb+g]);
      if (avgc_q.size() > ab + g && dv_q.size() > db + N*g + N-1)
        check({tag, "_avg_lat"}, avgc_q[ab+g] - dv_q[db+N*g+N-1], 1);
    end
    idx = first_fault(eb, ng, ovt, 1'b1);
    check({tag, "_ov_rises"}, ovr_q.size() - ob, int'(idx >= 0));
    check({tag, "_ov_level"}, int'(ov_fault), int'(idx >= 0));
    if (idx >= 0 && ovr_q.size() > ob && avgc_q.size() > ab + idx)
      check({tag, "_ov_rise_cyc"}, ovr_q[ob] - avgc_q[ab+idx], 1);
    idx = first_fault(eb, ng, uvt, 1'b0);
    check({tag, "_uv_rises"}, uvr_q.size() - ub, int'(idx >= 0));
    check({tag, "_uv_level"}, int'(uv_fault), int'(idx >= 0));
    if (idx >= 0 && uvr_q.size() > ub && avgc_q.size() > ab + idx)
      check({tag, "_uv_rise_cyc"}, uvr_q[ub] - avgc_q[ab+idx], 1);
  endtask

  initial begin
    int tb, ab, db, eb, ob, ub, tob, c;
    int ov_t[6] = '{2100, 2100, 1900, 2100, 2100, 2100};
    int uv_t[5] = '{500, 500, 499, 499, 499};

    repeat (3) @(negedge clk);
    check("rst_flags", int'({ad_trigger, avg_valid, ov_fault, uv_fault, ad_timeout, busy}), 0);
    check("rst_avg", int'(avg_data), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_disabled", int'({busy, ad_trigger}), 0);

    // block average of four fixed samples, trigger spacing
    tb = trig_q.size(); ab = avg_q.size(); db = dv_q.size(); eb = exp_avg.size();
    push4(100, 200, 300, 400);
    enable = 1'b1;
    wait_q(0, ab + 1, 6000, "t1_wait_avg");
    repeat (3) @(negedge clk);
    check("t1_avg_count", avg_q.size() - ab, 1);
    if (avg_q.size() > ab) check("t1_avg", avg_q[ab], exp_avg[eb]);
    if (avgc_q.size() > ab && dv_q.size() > db + 3) check("t1_avg_lat", avgc_q[ab] - dv_q[db+3], 1);
    for (int i = 1; i < 4; i++)
      if (trig_q.size() > tb + i) check("t1_trig_period", trig_q[tb+i] - trig_q[tb+i-1], SP);

    // unanswered conversion: timeout, next trigger on schedule, clear
    tob = tor_q.size();
    wait_q(2, tob + 1, 3000, "t2_wait_timeout");
    if (tor_q.size() > tob && trig_q.size() > tb + 4)
      check("t2_timeout_cyc", tor_q[tob] - trig_q[tb+4], TW + TO);
    wait_q(1, tb + 6, 1500, "t2_wait_trig");
    if (trig_q.size() > tb + 5) check("t2_trig_period", trig_q[tb+5] - trig_q[tb+4], SP);
    enable = 1'b0;
    wait_idle(2000, "t2_idle", c);
    check("t2_timeout_set", int'(ad_timeout), 1);
    pulse_clr();
    check("t2_timeout_clr", int'(ad_timeout), 0);

    // over-voltage debounce with one in-limit average breaking the run
    ov_thresh = 12'd2000; uv_thresh = 12'd100;
    ab = avg_q.size(); db = dv_q.size(); eb = exp_avg.size(); ob = ovr_q.size(); ub = uvr_q.size();
    foreach (ov_t[i]) gen_group(ov_t[i]);
    enable = 1'b1;
    wait_q(0, ab + 6, 6 * N * SP + 3000, "t3_wait_avg");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_idle(2000, "t3_idle", c);
    check_groups("t3", ab, eb, db, 6, ob, ub, 2000, 100);

    // under-voltage boundary: equal is in limit
    pulse_clr();
    check("t4_ov_clr", int'(ov_fault), 0);
    ov_thresh = 12'hFFF; uv_thresh = 12'd500;
    ab = avg_q.size(); db = dv_q.size(); eb = exp_avg.size(); ob = ovr_q.size(); ub = uvr_q.size();
    foreach (uv_t[i]) gen_group(uv_t[i]);
    enable = 1'b1;
    wait_q(0, ab + 5, 5 * N * SP + 3000, "t4_wait_avg");
    repeat (3) @(negedge clk);
    enable = 1'b0;
    wait_idle(2000, "t4_idle", c);
    check_groups("t4", ab, eb, db, 5, ob, ub, 4095, 500);

    // enable dropped during WAIT: conversion completes and its sample still counts
    tb = trig_q.size(); ab = avg_q.size(); db = dv_q.size(); eb = exp_avg.size();
    push4(1234, 1000, 2000, 3000);
    enable = 1'b1;
    wait_q(1, tb + 1, 100, "t5_wait_trig");
    repeat (10) @(negedge clk);
    enable = 1'b0;
    wait_idle(3000, "t5_idle", c);
    if (trig_q.size() > tb) check("t5_idle_cyc", c - trig_q[tb], SP);
    repeat (20) @(negedge clk);
    check("t5_dv_count", dv_q.size() - db, 1);
    check("t5_trig_count", trig_q.size() - tb, 1);
    check("t5_no_avg_yet", avg_q.size() - ab, 0);
    enable = 1'b1;
    wait_q(0, ab + 1, 4000, "t5_wait_avg");
    if (avg_q.size() > ab) check("t5_avg", avg_q[ab], exp_avg[eb]);
    check("t5_trig_total", trig_q.size() - tb, 4);

    // asynchronous reset while the trigger is high
    wait_q(1, tb + 5, 1500, "t6_wait_trig");
    check("t6_trig_high", int'(ad_trigger), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_flags", int'({ad_trigger, avg_valid, ov_fault, uv_fault, ad_timeout, busy}), 0);
    check("t6_rst_avg", int'(avg_data), 0);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_after_rst", int'({ad_trigger, busy, uv_fault}), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
